inst_fetch: RTL and testbench

- Instruction fetch stage that sits between the program-counter unit and the decoder.
- Samples the current fetch address, issues one request at a time to instruction memory over a req/ack handshake, and buffers returned words with their PC in a small FIFO.
- Presents buffered words to decode with valid/ready.
- Steps the PC unit with a one-cycle advance pulse and discards buffered and in-flight words on a branch flush.

---
 rtl/inst_fetch.sv | 198 +++++++++++++++++++
 tb/tb_inst_fetch.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// ----------------------------------------------------------------------------
// inst_fetch
//
// Instruction fetch stage between the PC unit and the decoder. It samples the
// fetch address when idle and issues one instruction-memory request at a time
// over a req/ack handshake. Returned words are buffered together with their PC
// in a small FIFO and presented to decode with valid/ready. A taken branch
// (flush) empties the buffer and discards any word still in flight.
//
// Parameters:
//   WIDTH  address / instruction width
//   DEPTH  instruction buffer entries (power of 2, minimum 2)
//
// Ports:
//   clk              clock, all state updates on the rising edge
//   rst              asynchronous reset, active low
//   pc_in            fetch address from the PC unit
//   pc_advance       one-cycle pulse telling the PC unit to step by 4
//   flush            taken branch/jump, the PC unit loads its target
//   imem_req         memory request, held until imem_ack
//   imem_addr        word-aligned request address, stable while imem_req=1
//   imem_ack         memory read data valid, completes the request
//   imem_rdata       instruction word returned with imem_ack
//   inst_valid       buffer head is valid
//   inst_ready       decode accepts the head entry
//   inst_out         head instruction word (0 when empty)
//   inst_pc          PC of the head instruction (0 when empty)
//   fetch_misaligned sticky misaligned-fetch flag (only with the macro below)
//
// Build option:
//   INST_FETCH_MISALIGN_TRAP_EN  when defined, a fetch address with non-zero
//   low bits raises fetch_misaligned instead of issuing; the flag blocks
//   further fetches until the next flush. When undefined, the low two address
//   bits are simply forced to zero.
// ----------------------------------------------------------------------------
module inst_fetch #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_in,
    output logic             pc_advance,
    input  logic             flush,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic [WIDTH-1:0] inst_out,
    output logic [WIDTH-1:0] inst_pc
`ifdef INST_FETCH_MISALIGN_TRAP_EN
    ,
    output logic             fetch_misaligned
`endif
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } state_t;

    state_t state, state_next;

    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] buf_inst [DEPTH];
    logic [WIDTH-1:0] buf_pc   [DEPTH];

    logic has_room;
    logic issue_allowed;
    logic issue;
    logic push;
    logic pop;

    assign has_room = (count < CNT_W'(DEPTH));

`ifdef INST_FETCH_MISALIGN_TRAP_EN
    logic misaligned_q;
    logic pc_low_bad;
    logic trap;

    assign pc_low_bad    = (pc_in[1:0] != 2'b00);
    assign issue_allowed = !misaligned_q && !pc_low_bad;
    // Trap fires exactly where an issue would otherwise have happened.
    assign trap = (state == IDLE) && !flush && has_room && !misaligned_q && pc_low_bad;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misaligned_q <= 1'b0;
        end else if (flush) begin
            misaligned_q <= 1'b0;
        end else if (trap) begin
            misaligned_q <= 1'b1;
        end
    end

    assign fetch_misaligned = misaligned_q;
`else
    // The low two address bits are dropped by alignment.
    logic unused_pc_low;
    assign unused_pc_low = &{1'b0, pc_in[1:0]};
    assign issue_allowed = 1'b1;
`endif

    // State register plus the registered request address and advance pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            pc_advance <= 1'b0;
            imem_addr  <= '0;
        end else begin
            state      <= state_next;
            pc_advance <= issue;
            if (issue) begin
                imem_addr <= {pc_in[WIDTH-1:2], 2'b00};
            end
        end
    end

    // Next-state logic. A flush while waiting does not retract the request;
    // DROP waits for the ack and throws the word away.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        push       = 1'b0;
        case (state)
            IDLE: begin
                if (!flush && has_room && issue_allowed) begin
                    issue      = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    push       = !flush;
                    state_next = IDLE;
                end else if (flush) begin
                    state_next = DROP;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request is outstanding in both REQ and DROP, so reset drops it at once.
    assign imem_req = (state != IDLE);

    assign pop = inst_valid && inst_ready && !flush;

    // FIFO pointers and occupancy; flush wins over a simultaneous push or pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Buffer storage needs no reset; the outputs are gated by inst_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_inst[wr_ptr] <= imem_rdata;
            buf_pc[wr_ptr]   <= imem_addr;
        end
    end

    assign inst_valid = (count != '0);
    assign inst_out   = inst_valid ? buf_inst[rd_ptr] : '0;
    assign inst_pc    = inst_valid ? buf_pc[rd_ptr]   : '0;

endmodule

// File: tb/tb_inst_fetch.sv
// ----------------------------------------------------------------------------
// tb_inst_fetch
//
// Self-checking bench for inst_fetch. A behavioural reference model (queue of
// buffered {pc, word} pairs plus a few flags for the outstanding request) is
// advanced on every clock edge with the same inputs the DUT sees, and all DUT
// outputs are compared against it one time unit after the edge. The bench
// also emulates the PC unit (step +4 on the advance pulse, load on flush) and
// the instruction memory (random words, ack only while a request is pending).
// ----------------------------------------------------------------------------
module tb_inst_fetch;

    localparam int WIDTH = 32;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] pc_in;
    logic             pc_advance;
    logic             flush;
    logic             imem_req;
    logic [WIDTH-1:0] imem_addr;
    logic             imem_ack;
    logic [WIDTH-1:0] imem_rdata;
    logic             inst_valid;
    logic             inst_ready;
    logic [WIDTH-1:0] inst_out;
    logic [WIDTH-1:0] inst_pc;
`ifdef INST_FETCH_MISALIGN_TRAP_EN
    logic             fetch_misaligned;
`endif

    inst_fetch #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .pc_in     (pc_in),
        .pc_advance(pc_advance),
        .flush     (flush),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .inst_valid(inst_valid),
        .inst_ready(inst_ready),
        .inst_out  (inst_out),
        .inst_pc   (inst_pc)
`ifdef INST_FETCH_MISALIGN_TRAP_EN
        ,
        .fetch_misaligned(fetch_misaligned)
`endif
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model state
    logic        m_busy;      // a request is outstanding
    logic        m_discard;   // outstanding word must be thrown away
    logic        m_adv;       // expected pc_advance
    logic        m_clean;     // buffer emptied by reset/flush, outputs read 0
    logic        m_mis;       // expected sticky misaligned flag
    logic [31:0] m_addr;      // expected request address
    logic [63:0] m_fifo [$];  // buffered {pc, word}, head at index 0
    logic [31:0] pc_reg;      // emulated PC unit

    logic [31:0] addr_log [$];

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        m_busy    = 1'b0;
        m_discard = 1'b0;
        m_adv     = 1'b0;
        m_clean   = 1'b1;
        m_mis     = 1'b0;
        m_addr    = 32'h0;
        m_fifo.delete();
    endtask

    // Advance the model by one clock edge using the inputs held across it.
    task automatic modelEdge(input logic f, input logic [31:0] target,
                             input logic ack, input logic [31:0] rdata,
                             input logic ready);
        int   occ;
        logic blocked;
        logic can_issue;
        occ     = m_fifo.size();
        blocked = 1'b0;
`ifdef INST_FETCH_MISALIGN_TRAP_EN
        blocked = m_mis || (pc_in[1:0] != 2'b00);
        if (f) m_mis = 1'b0;
        else if (!m_busy && occ < DEPTH && !m_mis && pc_in[1:0] != 2'b00) m_mis = 1'b1;
`endif
        can_issue = !m_busy && !f && (occ < DEPTH) && !blocked;

        if (f) begin
            m_fifo.delete();
            m_clean = 1'b1;
        end else begin
            if (occ != 0 && ready) void'(m_fifo.pop_front());
            if (m_busy && ack && !m_discard) begin
                m_fifo.push_back({m_addr, rdata});
                m_clean = 1'b0;
            end
        end

        if (m_busy && ack) begin
            m_busy    = 1'b0;
            m_discard = 1'b0;
        end else if (m_busy && f) begin
            m_discard = 1'b1;
        end

        if (f) pc_reg = target;
        else if (m_adv) pc_reg = pc_reg + 32'd4;

        m_adv = can_issue;
        if (can_issue) begin
            m_busy = 1'b1;
            m_addr = {pc_in[31:2], 2'b00};
        end
    endtask

    task automatic compareAll();
        logic [63:0] head;
        checkOutput("imem_req", 32'(imem_req), 32'(m_busy));
        checkOutput("pc_advance", 32'(pc_advance), 32'(m_adv));
        if (m_busy) checkOutput("imem_addr", imem_addr, m_addr);
        checkOutput("inst_valid", 32'(inst_valid), 32'(m_fifo.size() != 0));
        if (m_fifo.size() != 0) begin
            head = m_fifo[0];
            checkOutput("inst_out", inst_out, head[31:0]);
            checkOutput("inst_pc", inst_pc, head[63:32]);
        end else if (m_clean) begin
            checkOutput("inst_out_empty", inst_out, 32'h0);
            checkOutput("inst_pc_empty", inst_pc, 32'h0);
        end
`ifdef INST_FETCH_MISALIGN_TRAP_EN
        checkOutput("fetch_misaligned", 32'(fetch_misaligned), 32'(m_mis));
`endif
    endtask

    // One clock cycle: drive inputs, take the edge, update model, compare.
    task automatic applyStimulus(input logic f, input logic [31:0] target,
                                 input logic ack, input logic ready);
        logic [31:0] rdata;
        rdata      = $urandom;
        flush      = f;
        imem_ack   = ack;
        imem_rdata = rdata;
        inst_ready = ready;
        pc_in      = pc_reg;
        @(posedge clk);
        modelEdge(f, target, ack, rdata, ready);
        #1;
        compareAll();
        if (pc_advance) addr_log.push_back(imem_addr);
    endtask

    initial begin
        logic        found;
        logic [31:0] restart;
        logic [31:0] seen;
        logic [31:0] target;
        logic        f;

        rst        = 1'b1;
        flush      = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        inst_ready = 1'b0;
        pc_reg     = 32'h0;
        pc_in      = 32'h0;
        modelReset();
        #1 rst = 1'b0;
        #11;
        checkOutput("rst_imem_req", 32'(imem_req), 32'h0);
        checkOutput("rst_imem_addr", imem_addr, 32'h0);
        checkOutput("rst_pc_advance", 32'(pc_advance), 32'h0);
        checkOutput("rst_inst_valid", 32'(inst_valid), 32'h0);
        checkOutput("rst_inst_out", inst_out, 32'h0);
        checkOutput("rst_inst_pc", inst_pc, 32'h0);
`ifdef INST_FETCH_MISALIGN_TRAP_EN
        checkOutput("rst_fetch_misaligned", 32'(fetch_misaligned), 32'h0);
`endif
        rst = 1'b1;

        // Sequential fetch from 0 with immediate acks and decode always ready.
        addr_log.delete();
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, m_busy, 1'b1);
        for (int i = 0; i < 3; i++) begin
            seen = (i < addr_log.size()) ? addr_log[i] : 32'hFFFF_FFFF;
            checkOutput($sformatf("seq_addr%0d", i), seen, 32'(4 * i));
        end

        // Decode stalled: buffer fills, fetching stops, then drains.
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, m_busy, 1'b0);
        checkOutput("full_no_req", 32'(imem_req), 32'h0);
        checkOutput("full_valid", 32'(inst_valid), 32'h1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b0, 32'h0, m_busy, 1'b1);

        // Flush while a request waits; ack arrives three cycles later.
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
            found = m_busy;
        end
        checkOutput("drop_setup", 32'(found), 32'h1);
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("drop_req_held", 32'(imem_req), 32'h1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("drop_discard_valid", 32'(inst_valid), 32'h0);
        addr_log.delete();
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, m_busy, 1'b1);
        seen = (addr_log.size() != 0) ? addr_log[0] : 32'hFFFF_FFFF;
        checkOutput("addr_after_flush", seen, 32'h100);

        // Flush together with ack while one entry is buffered.
        applyStimulus(1'b1, 32'h200, m_busy, 1'b0);
        found = 1'b0;
        for (int i = 0; i < 12 && !found; i++) begin
            applyStimulus(1'b0, 32'h0, m_busy, 1'b0);
            found = m_busy && (m_fifo.size() == 1);
        end
        checkOutput("flush_ack_setup", 32'(found), 32'h1);
        applyStimulus(1'b1, 32'h300, 1'b1, 1'b0);
        checkOutput("flush_ack_valid", 32'(inst_valid), 32'h0);
        checkOutput("flush_ack_no_req", 32'(imem_req), 32'h0);
        checkOutput("flush_ack_no_adv", 32'(pc_advance), 32'h0);

        // Asynchronous reset in the middle of a request.
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
            found = m_busy;
        end
        checkOutput("async_setup", 32'(found), 32'h1);
        #2 rst = 1'b0;
        #1;
        checkOutput("async_imem_req", 32'(imem_req), 32'h0);
        checkOutput("async_inst_valid", 32'(inst_valid), 32'h0);
        checkOutput("async_pc_advance", 32'(pc_advance), 32'h0);
        modelReset();
        @(posedge clk);
        #3 rst = 1'b1;
        restart = {pc_reg[31:2], 2'b00};
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("restart_addr", imem_addr, restart);

`ifdef INST_FETCH_MISALIGN_TRAP_EN
        // Misaligned fetch address traps until a flush to an aligned target.
        for (int i = 0; i < 6 && m_busy; i++) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        pc_reg = 32'h6;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("mis_flag", 32'(fetch_misaligned), 32'h1);
        checkOutput("mis_no_req", 32'(imem_req), 32'h0);
        applyStimulus(1'b1, 32'h8, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("mis_cleared", 32'(fetch_misaligned), 32'h0);
        checkOutput("mis_req_addr", imem_addr, 32'h8);
`endif

        // Randomized traffic: flushes, stalls, variable memory latency.
        for (int i = 0; i < 1500; i++) begin
            f = ($urandom_range(0, 15) == 0);
`ifdef INST_FETCH_MISALIGN_TRAP_EN
            target = ($urandom_range(0, 5) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
`else
            target = $urandom;
`endif
            applyStimulus(f, target, m_busy && ($urandom_range(0, 2) != 0),
                          $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
